// File: rtl/osc_pkg.sv
// Shared oscilloscope types: sample/span formats, buffer geometry and the reader FSM encoding.
package osc_pkg;

  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned N_SAMPLES = 512;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned YPIX_W    = 9;
  localparam int unsigned COORD_W   = 11;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [YPIX_W-1:0]   ypix_t;

  typedef struct packed {
    logic [YPIX_W-1:0] lo;
    logic [YPIX_W-1:0] hi;
  } span_t;

  typedef enum logic [1:0] {IDLE, ARMED, COPY, REARM} rd_state_t;

  // Full-scale sample maps to row 0 (top of the trace window).
  function automatic ypix_t sample_to_y(input sample_t s, input int unsigned yshift);
    sample_t diff;
    diff = sample_t'('1) - s;
    return ypix_t'(diff >> yshift);
  endfunction

endpackage

// File: rtl/wave_reader_if.sv
// Capture-buffer and video-timing bus between wave_reader and its surroundings.
interface wave_reader_if;
  import osc_pkg::*;

  logic                cap_done;
  logic                cap_rearm;
  logic [ADDR_W-1:0]   rd_addr;
  sample_t             rd_data;
  logic                vblank;
  logic [COORD_W-1:0]  hcount;
  logic [COORD_W-1:0]  vcount;
  logic                trace_pix;
  logic                frame_ok;

  modport master (
    input  cap_done, rd_data, vblank, hcount, vcount,
    output cap_rearm, rd_addr, trace_pix, frame_ok
  );

  modport slave (
    output cap_done, rd_data, vblank, hcount, vcount,
    input  cap_rearm, rd_addr, trace_pix, frame_ok
  );

endinterface

// File: rtl/wave_span_ram.sv
// Simple dual-port 512 x span_t trace RAM: copy-side write port, registered render-side read port.
module wave_span_ram
  import osc_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  span_t             wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output span_t             rd_data
);

  span_t mem [N_SAMPLES];
  span_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_reader.sv
// Copies a completed capture into the local trace RAM during vblank and renders it
// as a 1-bit pixel stream with vertically adjacent samples joined.
module wave_reader
  import osc_pkg::*;
#(
  parameter int unsigned X0     = 256,
  parameter int unsigned Y0     = 128,
  parameter int unsigned YSHIFT = 3
) (
  input logic           clk,
  input logic           rst,
  wave_reader_if.master bus
);

  localparam logic [ADDR_W:0]    CNT_FIRST = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]    CNT_LAST  = (ADDR_W+1)'(N_SAMPLES);
  localparam logic [COORD_W-1:0] X_LO      = COORD_W'(X0);
  localparam logic [COORD_W-1:0] X_HI      = COORD_W'(X0 + N_SAMPLES);
  localparam logic [COORD_W-1:0] Y_TOP     = COORD_W'(Y0);

  rd_state_t          state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  ypix_t              prev_y_q, prev_y_d;
  logic               frame_ok_q, frame_ok_d;
  logic               in_x_q, in_x_d;
  logic [COORD_W-1:0] vcount_q, vcount_d;
  logic               trace_pix_q, trace_pix_d;

  ypix_t              cur_y;
  logic               cap_rearm;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  span_t              wr_data;
  logic [ADDR_W-1:0]  col_addr;
  span_t              span_rd;
  logic [COORD_W-1:0] row_lo, row_hi;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.vblank) state_d = ARMED;
      ARMED:   if (bus.vblank && bus.cap_done) state_d = COPY;
      COPY:    if (cnt_q == CNT_LAST) state_d = REARM;
      REARM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample i arrives the cycle after its address, so entry cnt-1 is written while cnt is issued;
  // the final COPY cycle (cnt=512) only drains the last sample.
  always_comb begin
    cnt_d      = '0;
    rd_addr_d  = '0;
    prev_y_d   = prev_y_q;
    frame_ok_d = frame_ok_q;
    cap_rearm  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = cnt_q[ADDR_W-1:0] - 1'b1;
    wr_data    = '0;
    cur_y      = sample_to_y(bus.rd_data, YSHIFT);

    unique case (state_q)
      COPY: begin
        cnt_d     = cnt_q + 1'b1;
        rd_addr_d = (rd_addr_q == '1) ? rd_addr_q : rd_addr_q + 1'b1;
        if (cnt_q != '0) begin
          wr_en    = 1'b1;
          prev_y_d = cur_y;
          if (cnt_q == CNT_FIRST) begin
            wr_data.lo = cur_y;
            wr_data.hi = cur_y;
          end else if (cur_y < prev_y_q) begin
            wr_data.lo = cur_y;
            wr_data.hi = prev_y_q;
          end else begin
            wr_data.lo = prev_y_q;
            wr_data.hi = cur_y;
          end
        end
      end
      REARM: begin
        cap_rearm  = 1'b1;
        frame_ok_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    col_addr    = bus.hcount[ADDR_W-1:0] - X_LO[ADDR_W-1:0];
    in_x_d      = (bus.hcount >= X_LO) && (bus.hcount < X_HI);
    vcount_d    = bus.vcount;
    row_lo      = Y_TOP + COORD_W'(span_rd.lo);
    row_hi      = Y_TOP + COORD_W'(span_rd.hi);
    trace_pix_d = frame_ok_q && in_x_q && (vcount_q >= row_lo) && (vcount_q <= row_hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      frame_ok_q  <= 1'b0;
      trace_pix_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      frame_ok_q  <= frame_ok_d;
      trace_pix_q <= trace_pix_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_y_q <= prev_y_d;
    in_x_q   <= in_x_d;
    vcount_q <= vcount_d;
  end

  wave_span_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (col_addr),
    .rd_data (span_rd)
  );

  assign bus.cap_rearm = cap_rearm;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.trace_pix = trace_pix_q;
  assign bus.frame_ok  = frame_ok_q;

endmodule

// File: tb/tb_wave_reader.sv
// Directed bench for wave_reader: copy timing, rendering of ramp/constant/step traces,
// blank handling and reset during a copy.
module tb_wave_reader;
  import osc_pkg::*;

  localparam int unsigned X0 = 256;
  localparam int unsigned Y0 = 128;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        exp;
  } pix_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_reader_if bus ();

  wave_reader #(.X0(X0), .Y0(Y0), .YSHIFT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sample_t     cap_mem [512];
  int unsigned rearm_cnt = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  always @(posedge clk) bus.rd_data <= cap_mem[bus.rd_addr];
  always @(posedge clk) if (bus.cap_rearm) rearm_cnt <= rearm_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic exp, input string name);
    bus.hcount = h;
    bus.vcount = v;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s h=%0d v=%0d", name, h, v), bus.trace_pix, exp);
  endtask

  task automatic run_copy(input string name);
    logic seen;
    seen = 1'b0;
    bus.vblank = 1'b0;
    tick();
    bus.vblank = 1'b1;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (bus.cap_rearm) seen = 1'b1;
    end
    check({name, " rearm seen"}, seen, 1'b1);
    tick();
    bus.vblank = 1'b0;
    check({name, " frame_ok"}, bus.frame_ok, 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pix_vec_t    ramp_vecs [15];
    int unsigned rearm_before;
    logic        found;
    logic [8:0]  max_addr;

    ramp_vecs[0]  = '{h: 11'd255, v: 11'd639, exp: 1'b0};
    ramp_vecs[1]  = '{h: 11'd768, v: 11'd128, exp: 1'b0};
    ramp_vecs[2]  = '{h: 11'd768, v: 11'd639, exp: 1'b0};
    ramp_vecs[3]  = '{h: 11'd256, v: 11'd639, exp: 1'b1};
    ramp_vecs[4]  = '{h: 11'd256, v: 11'd638, exp: 1'b0};
    ramp_vecs[5]  = '{h: 11'd266, v: 11'd629, exp: 1'b1};
    ramp_vecs[6]  = '{h: 11'd266, v: 11'd630, exp: 1'b1};
    ramp_vecs[7]  = '{h: 11'd266, v: 11'd628, exp: 1'b0};
    ramp_vecs[8]  = '{h: 11'd266, v: 11'd631, exp: 1'b0};
    ramp_vecs[9]  = '{h: 11'd767, v: 11'd128, exp: 1'b1};
    ramp_vecs[10] = '{h: 11'd767, v: 11'd129, exp: 1'b1};
    ramp_vecs[11] = '{h: 11'd767, v: 11'd130, exp: 1'b0};
    ramp_vecs[12] = '{h: 11'd767, v: 11'd127, exp: 1'b0};
    ramp_vecs[13] = '{h: 11'd512, v: 11'd383, exp: 1'b1};
    ramp_vecs[14] = '{h: 11'd512, v: 11'd385, exp: 1'b0};

    bus.cap_done = 1'b0;
    bus.vblank   = 1'b0;
    bus.hcount   = '0;
    bus.vcount   = '0;
    for (int i = 0; i < 512; i++) cap_mem[i] = sample_t'(i * 8);

    repeat (3) tick();
    check("reset cap_rearm", bus.cap_rearm, 1'b0);
    check("reset rd_addr", bus.rd_addr, 0);
    check("reset trace_pix", bus.trace_pix, 1'b0);
    check("reset frame_ok", bus.frame_ok, 1'b0);
    rst = 1'b0;

    pix(11'(X0), 11'(Y0), 1'b0, "pre-copy");
    pix(11'(X0 + 100), 11'(Y0 + 200), 1'b0, "pre-copy");
    pix(11'(X0 + 511), 11'(Y0 + 511), 1'b0, "pre-copy");

    // Blank without cap_done: nothing read, no rearm; then raise cap_done mid-blank.
    bus.vblank = 1'b0;
    tick();
    bus.vblank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle blank rd_addr", bus.rd_addr, 0);
      check("idle blank cap_rearm", bus.cap_rearm, 1'b0);
    end
    check("idle blank rearm count", rearm_cnt, 0);

    bus.cap_done = 1'b1;
    for (int k = 1; k <= 514; k++) begin
      tick();
      if (k <= 512) check($sformatf("sweep rd_addr k=%0d", k), bus.rd_addr, k - 1);
      check($sformatf("cap_rearm k=%0d", k), bus.cap_rearm, (k == 514));
    end
    tick();
    check("ramp frame_ok", bus.frame_ok, 1'b1);
    check("ramp rearm single", bus.cap_rearm, 1'b0);

    max_addr = '0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (bus.rd_addr > max_addr) max_addr = bus.rd_addr;
    end
    check("one copy per frame rearm count", rearm_cnt, 1);
    check("one copy per frame rd_addr", max_addr, 0);
    bus.vblank = 1'b0;

    for (int i = 0; i < 15; i++)
      pix(ramp_vecs[i].h, ramp_vecs[i].v, ramp_vecs[i].exp, $sformatf("ramp vec%0d", i));

    // Constant full-scale: every column lights exactly row Y0.
    for (int i = 0; i < 512; i++) cap_mem[i] = 12'hFFF;
    run_copy("const");
    for (int i = 0; i < 512; i++) begin
      pix(11'(X0 + i), 11'(Y0), 1'b1, "const top");
      pix(11'(X0 + i), 11'(Y0 + 1), 1'b0, "const below");
    end

    // Step from full-scale to zero at sample 256.
    for (int i = 0; i < 512; i++) cap_mem[i] = (i < 256) ? 12'hFFF : 12'h000;
    run_copy("step");
    for (int v = 0; v < 512; v++) begin
      pix(11'(X0 + 256), 11'(Y0 + v), 1'b1, "step edge");
      pix(11'(X0 + 255), 11'(Y0 + v), (v == 0), "step before");
    end
    pix(11'(X0 + 256), 11'(Y0 - 1), 1'b0, "step edge above");
    pix(11'(X0 - 1), 11'(Y0), 1'b0, "step left");
    pix(11'(X0 + 512), 11'(Y0 + 511), 1'b0, "step right");

    // Reset asserted at copy index 200.
    bus.vblank = 1'b0;
    tick();
    bus.vblank = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (bus.rd_addr == 9'd200) found = 1'b1;
    end
    check("reach index 200", found, 1'b1);
    rearm_before = rearm_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-copy reset frame_ok", bus.frame_ok, 1'b0);
    check("mid-copy reset rd_addr", bus.rd_addr, 0);
    repeat (600) tick();
    check("mid-copy reset no rearm", rearm_cnt, rearm_before);
    bus.vblank = 1'b0;
    pix(11'(X0 + 256), 11'(Y0 + 100), 1'b0, "after reset");
    pix(11'(X0), 11'(Y0), 1'b0, "after reset");
    pix(11'(X0 + 300), 11'(Y0 + 511), 1'b0, "after reset");
    run_copy("recopy");
    check("recopy rearm count", rearm_cnt, rearm_before + 1);
    pix(11'(X0 + 256), 11'(Y0 + 300), 1'b1, "recopy");
    pix(11'(X0 + 255), 11'(Y0 + 1), 1'b0, "recopy");
    pix(11'(X0 + 10), 11'(Y0), 1'b1, "recopy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
